// File: rtl/pulse_width_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_width_meter_pkg
// Description : Shared types and constants for the pulse width meter.
//               - state_t     : measurement FSM states
//               - SYNC_STAGES : depth of the optional input synchroniser
// Macro       : PULSE_WIDTH_METER_SYNC_EN (consumed by sync_edge_detect)
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_width_meter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MEASURE  = 2'b01,
    WAIT_LOW = 2'b10
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage : pulse_width_meter_pkg
`default_nettype wire

// File: rtl/pulse_width_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_width_meter_if
// Description : Signal bundle between a pulse source/consumer and the meter.
//               Names are given from the meter's point of view.
//   i_pulse_in  : pulse being measured, active high
//   i_enable    : arms measurement; low aborts a measurement in progress
//   o_width     : width of the last accepted pulse (held until next valid)
//   o_valid     : one-cycle strobe when o_width/o_overflow update
//   o_overflow  : last reported pulse exceeded MAX_COUNT
//   o_busy      : meter state is not IDLE
//   modport master : drives pulse/enable, observes results
//   modport slave  : the meter itself
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_width_meter_if #(
  parameter int BIT_WIDTH = 12
);

  logic                 i_pulse_in;
  logic                 i_enable;
  logic [BIT_WIDTH-1:0] o_width;
  logic                 o_valid;
  logic                 o_overflow;
  logic                 o_busy;

  modport master (
    output i_pulse_in,
    output i_enable,
    input  o_width,
    input  o_valid,
    input  o_overflow,
    input  o_busy
  );

  modport slave (
    input  i_pulse_in,
    input  i_enable,
    output o_width,
    output o_valid,
    output o_overflow,
    output o_busy
  );

endinterface : pulse_width_meter_if
`default_nettype wire

// File: rtl/pulse_width_meter_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Input conditioning for a single-bit level: optional
//               synchroniser, previous-sample flop and rising-edge detect.
//   i_clk   : clock (posedge)
//   i_rst_n : asynchronous active-low reset
//   i_sig   : raw input level
//   o_s     : conditioned sample
//   o_rise  : o_s high while previous sample was low
// Macro       : PULSE_WIDTH_METER_SYNC_EN - when defined, i_sig passes
//               through a SYNC_STAGES-deep flop chain before o_s.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect
  import pulse_width_meter_pkg::*;
(
  input  wire logic i_clk,
  input  wire logic i_rst_n,
  input  wire logic i_sig,
  output logic      o_s,
  output logic      o_rise
);

  logic       w_s;
  logic       r_prev;
  logic [1:0] r_prime_cnt;
  logic       w_primed;

`ifdef PULSE_WIDTH_METER_SYNC_EN
  localparam int PRIME_CYCLES = SYNC_STAGES + 1;

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];
`else
  localparam int PRIME_CYCLES = 1;

  assign w_s = i_sig;
`endif

  // Until r_prev holds a genuine sample of the input, a high level could
  // only be a pulse that was already in progress at reset release; such a
  // pulse must not look like a rise, so edge detect stays gated until the
  // pipeline has filled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev      <= 1'b0;
      r_prime_cnt <= 2'd0;
    end else begin
      r_prev <= w_s;
      if (!w_primed) begin
        r_prime_cnt <= r_prime_cnt + 2'd1;
      end
    end
  end

  assign w_primed = (r_prime_cnt == 2'(PRIME_CYCLES));
  assign o_s      = w_s;
  assign o_rise   = w_s & ~r_prev & w_primed;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/pulse_width_meter.sv
`default_nettype none
// ============================================================================
// Module      : pulse_width_meter
// Description : Measures high-pulse width in clock periods and reports each
//               accepted pulse with a one-cycle valid strobe. Pulses shorter
//               than MIN_COUNT are dropped; pulses longer than MAX_COUNT are
//               reported once as MAX_COUNT with overflow set.
//   i_clk   : clock (posedge)
//   i_rst_n : asynchronous active-low reset
//   io_bus  : pulse_width_meter_if.slave (pulse_in, enable, width, valid,
//             overflow, busy)
// Macro       : PULSE_WIDTH_METER_SYNC_EN - adds a 2-flop input synchroniser
//               (+2 cycles latency, widths unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int MAX_COUNT = 4095,
  parameter int MIN_COUNT = 2,
  parameter int BIT_WIDTH = $clog2(MAX_COUNT + 1)
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst_n,
  pulse_width_meter_if.slave   io_bus
);

  localparam logic [BIT_WIDTH-1:0] c_max_cnt = BIT_WIDTH'(MAX_COUNT);
  localparam logic [BIT_WIDTH-1:0] c_min_cnt = BIT_WIDTH'(MIN_COUNT);

  logic                 w_s;
  logic                 w_rise;

  state_t               r_state;
  logic [BIT_WIDTH-1:0] r_count;
  logic [BIT_WIDTH-1:0] r_width;
  logic                 r_valid;
  logic                 r_overflow;
  logic                 r_busy;

  sync_edge_detect u_sync_edge_detect (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (io_bus.i_pulse_in),
    .o_s     (w_s),
    .o_rise  (w_rise)
  );

  // r_busy is updated together with every r_state assignment so that it
  // always equals (r_state != IDLE) without a decode on the output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_width    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise && io_bus.i_enable) begin
            r_state <= MEASURE;
            r_busy  <= 1'b1;
            r_count <= BIT_WIDTH'(1);
          end
        end

        MEASURE: begin
          // Disable wins over every other transition on the same edge.
          if (!io_bus.i_enable) begin
            if (w_s) begin
              r_state <= WAIT_LOW;
              r_busy  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_s) begin
            if (r_count == c_max_cnt) begin
              // Report saturation once, then ignore the rest of the pulse.
              r_state    <= WAIT_LOW;
              r_busy     <= 1'b1;
              r_valid    <= 1'b1;
              r_width    <= c_max_cnt;
              r_overflow <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (r_count >= c_min_cnt) begin
              r_valid    <= 1'b1;
              r_width    <= r_count;
              r_overflow <= 1'b0;
            end
          end
        end

        WAIT_LOW: begin
          // Whether or not enabled, only the fall of the pulse leaves here.
          if (!w_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.o_width    = r_width;
  assign io_bus.o_valid    = r_valid;
  assign io_bus.o_overflow = r_overflow;
  assign io_bus.o_busy     = r_busy;

endmodule : pulse_width_meter
`default_nettype wire

// File: tb/tb_pulse_width_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_width_meter
// Description : Directed self-checking bench for pulse_width_meter with
//               MAX_COUNT=15, MIN_COUNT=2. Inputs change 1 time unit after
//               the rising edge; outputs are sampled at the same point.
// Macro       : PULSE_WIDTH_METER_SYNC_EN shifts expected valid latency by 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_width_meter;
  import pulse_width_meter_pkg::*;

  localparam int MAX_COUNT = 15;
  localparam int MIN_COUNT = 2;
  localparam int BIT_WIDTH = 4;
`ifdef PULSE_WIDTH_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst_n;

  pulse_width_meter_if #(.BIT_WIDTH(BIT_WIDTH)) bus ();

  pulse_width_meter #(
    .MAX_COUNT (MAX_COUNT),
    .MIN_COUNT (MIN_COUNT),
    .BIT_WIDTH (BIT_WIDTH)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observation window results
  int   k;
  int   nv;
  int   vc;
  int   bc;
  logic [BIT_WIDTH-1:0] w_first;
  logic [BIT_WIDTH-1:0] w_last;
  logic ov_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    k = 0; nv = 0; vc = -1; bc = 0;
    w_first = '0; w_last = '0; ov_last = 1'b0;
  endtask

  task automatic obs();
    @(posedge clk);
    #1;
    k++;
    if (bus.o_valid === 1'b1) begin
      nv++;
      vc = k;
      if (nv == 1) w_first = bus.o_width;
      w_last  = bus.o_width;
      ov_last = bus.o_overflow;
    end
    if (bus.o_busy === 1'b1) bc++;
  endtask

  task automatic run_pulse(input int hi, input int lo);
    clear_obs();
    bus.i_pulse_in = 1'b1;
    repeat (hi) obs();
    bus.i_pulse_in = 1'b0;
    repeat (lo + LAT) obs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.i_enable   = 1'b0;
    bus.i_pulse_in = 1'b0;

    // Reset held while the input toggles
    clear_obs();
    for (int i = 0; i < 6; i++) begin
      bus.i_pulse_in = ~bus.i_pulse_in;
      obs();
    end
    chk("rst_width",    32'(bus.o_width),    32'd0);
    chk("rst_valid",    32'(bus.o_valid),    32'd0);
    chk("rst_overflow", 32'(bus.o_overflow), 32'd0);
    chk("rst_busy",     32'(bus.o_busy),     32'd0);
    chk("rst_nvalid",   32'(nv),             32'd0);

    bus.i_pulse_in = 1'b0;
    rst_n          = 1'b1;
    bus.i_enable   = 1'b1;
    clear_obs();
    repeat (4) obs();
    chk("idle_busy", 32'(bc), 32'd0);

    // 5-cycle pulse
    run_pulse(5, 4);
    chk("p5_nvalid", 32'(nv),      32'd1);
    chk("p5_width",  32'(w_last),  32'd5);
    chk("p5_ovf",    32'(ov_last), 32'd0);
    chk("p5_vcycle", 32'(vc),      32'(6 + LAT));
    chk("p5_busy",   32'(bc),      32'd5);

    // Glitch is dropped, then a minimum-width pulse is reported
    run_pulse(1, 4);
    chk("p1_nvalid", 32'(nv), 32'd0);
    chk("p1_busy",   32'(bc), 32'd1);
    chk("p1_width_held", 32'(bus.o_width), 32'd5);
    run_pulse(2, 4);
    chk("p2_nvalid", 32'(nv),     32'd1);
    chk("p2_width",  32'(w_last), 32'd2);

    // Largest normal width, then saturation
    run_pulse(15, 4);
    chk("p15_nvalid", 32'(nv),      32'd1);
    chk("p15_width",  32'(w_last),  32'd15);
    chk("p15_ovf",    32'(ov_last), 32'd0);
    run_pulse(16, 4);
    chk("p16_nvalid", 32'(nv),      32'd1);
    chk("p16_width",  32'(w_last),  32'd15);
    chk("p16_ovf",    32'(ov_last), 32'd1);
    chk("p16_vcycle", 32'(vc),      32'(16 + LAT));
    chk("p16_busy",   32'(bc),      32'd16);
    chk("p16_ovf_held", 32'(bus.o_overflow), 32'd1);

    // Back-to-back: 3 high, 1 low, 4 high
    clear_obs();
    bus.i_pulse_in = 1'b1; repeat (3) obs();
    bus.i_pulse_in = 1'b0; obs();
    bus.i_pulse_in = 1'b1; repeat (4) obs();
    bus.i_pulse_in = 1'b0; repeat (4 + LAT) obs();
    chk("b2b_nvalid", 32'(nv),      32'd2);
    chk("b2b_first",  32'(w_first), 32'd3);
    chk("b2b_second", 32'(w_last),  32'd4);
    chk("b2b_ovf",    32'(ov_last), 32'd0);

    // Enable dropped on the 3rd measuring edge of a 10-cycle pulse
    clear_obs();
    bus.i_pulse_in = 1'b1;
    repeat (2 + LAT) obs();
    bus.i_enable = 1'b0;
    obs();
    chk("abort_state", 32'(dut.r_state), 32'(WAIT_LOW));
    bus.i_enable = 1'b1;
    repeat (10 - 3 - LAT) obs();
    chk("abort_busy_hi", 32'(bus.o_busy), 32'd1);
    bus.i_pulse_in = 1'b0;
    repeat (4 + LAT) obs();
    chk("abort_nvalid", 32'(nv),           32'd0);
    chk("abort_width",  32'(bus.o_width),  32'd4);
    chk("abort_busy",   32'(bus.o_busy),   32'd0);

    // Asynchronous reset during a measurement
    clear_obs();
    bus.i_pulse_in = 1'b1;
    repeat (3 + LAT) obs();
    chk("ar_busy_before", 32'(bus.o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_width",    32'(bus.o_width),    32'd0);
    chk("ar_busy",     32'(bus.o_busy),     32'd0);
    chk("ar_overflow", 32'(bus.o_overflow), 32'd0);
    chk("ar_valid",    32'(bus.o_valid),    32'd0);

    // Pulse already high at reset release is not measured
    obs();
    rst_n = 1'b1;
    clear_obs();
    repeat (5) obs();
    bus.i_pulse_in = 1'b0;
    repeat (4 + LAT) obs();
    chk("hi_at_release_nvalid", 32'(nv), 32'd0);

    // Normal operation resumes afterwards
    run_pulse(7, 4);
    chk("p7_nvalid", 32'(nv),     32'd1);
    chk("p7_width",  32'(w_last), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pulse_width_meter
`default_nettype wire
